// File: rtl/axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter
//
// Write-channel arbiter and sequencer for the AXI interconnect. One of
// MasterCount masters requesting on AW wins the channel. The winner keeps the
// grant through its W burst and its B response. The block drives the state
// and sel_Master controls used by the AW/W/B multiplexers. It also checks
// each burst length against WLAST and records any mismatch.
//
// Build option:
//   WARB_FIXED_PRIO_EN  when defined, the lowest requesting index always
//                       wins and the round-robin pointer is removed.
//                       When undefined (the default), round-robin is used.
//
// Ports:
//   ACLK        system clock
//   ARESETn     asynchronous active-low reset
//   AWVALID_MS  per-master AWVALID
//   AWLEN_MS    per-master AWLEN, packed; master i at [i*LenBits +: LenBits]
//   AWREADY_S   AWREADY from the addressed slave
//   WVALID      muxed WVALID
//   WREADY_S    slave WREADY
//   WLAST       muxed WLAST
//   BVALID_S    slave BVALID
//   BREADY      muxed BREADY of the granted master
//   state       2'b00 idle, 2'b01 W transfer, 2'b10 B response
//   sel_Master  one-hot grant, all-zero when nobody is selected
//   busy        high whenever state is not idle
//   beat_cnt    W beats accepted in the current burst
//   wlast_err   sticky burst-length / WLAST mismatch flag
// ---------------------------------------------------------------------------
module axi_write_arbiter #(
  parameter int MasterCount = 2,
  parameter int LenBits     = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [MasterCount-1:0]         AWVALID_MS,
  input  logic [MasterCount*LenBits-1:0] AWLEN_MS,
  input  logic                           AWREADY_S,
  input  logic                           WVALID,
  input  logic                           WREADY_S,
  input  logic                           WLAST,
  input  logic                           BVALID_S,
  input  logic                           BREADY,
  output logic [1:0]                     state,
  output logic [MasterCount-1:0]         sel_Master,
  output logic                           busy,
  output logic [LenBits-1:0]             beat_cnt,
  output logic                           wlast_err
);

  localparam int IdxBits = (MasterCount > 1) ? $clog2(MasterCount) : 1;

  typedef enum logic [1:0] {
    WRITESTATE_IDLE   = 2'b00,
    WRITESTATE_WTRANS = 2'b01,
    WRITESTATE_BTRANS = 2'b10
  } write_state_e;

  write_state_e               state_q;
  write_state_e               state_d;
  logic                       busy_q;
  logic [MasterCount-1:0]     grant_q;
  logic [LenBits-1:0]         len_q;
  logic                       cand_found;
  logic [IdxBits-1:0]         cand_idx;
  logic [MasterCount-1:0]     cand_onehot;
  logic [LenBits-1:0]         cand_len;
  logic                       aw_hs;
  logic                       w_beat;
  logic                       b_hs;
  logic                       len_mismatch;

`ifdef WARB_FIXED_PRIO_EN
  // The lowest set request bit wins. The loop scans downward, so the last
  // assignment made is the lowest index.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = MasterCount - 1; i >= 0; i--) begin
      if (AWVALID_MS[i]) begin
        cand_found = 1'b1;
        cand_idx   = IdxBits'(i);
      end
    end
  end
`else
  logic [IdxBits-1:0]     rr_ptr_q;
  logic [IdxBits-1:0]     grant_idx_q;
  logic [MasterCount-1:0] req_rot;
  logic [IdxBits:0]       idx_sum;

  // The requests are rotated so that bit 0 is the master at the pointer.
  // The downward scan leaves the first requester at or after the pointer.
  // Its position is then mapped back to an absolute index, modulo the
  // master count.
  always_comb begin
    req_rot    = MasterCount'({AWVALID_MS, AWVALID_MS} >> rr_ptr_q);
    idx_sum    = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = MasterCount - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        idx_sum = {1'b0, rr_ptr_q} + (IdxBits+1)'(k);
        if (idx_sum >= (IdxBits+1)'(MasterCount)) begin
          idx_sum = idx_sum - (IdxBits+1)'(MasterCount);
        end
        cand_found = 1'b1;
        cand_idx   = idx_sum[IdxBits-1:0];
      end
    end
  end

  // After each completed B response, the master after the one just served
  // gets top priority.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      if (aw_hs) begin
        grant_idx_q <= cand_idx;
      end
      if (b_hs) begin
        rr_ptr_q <= (grant_idx_q == IdxBits'(MasterCount - 1)) ?
                    '0 : grant_idx_q + IdxBits'(1);
      end
    end
  end
`endif

  // One-hot form of the candidate, and the candidate's AWLEN field.
  always_comb begin
    cand_onehot = '0;
    cand_len    = '0;
    for (int i = 0; i < MasterCount; i++) begin
      if (cand_found && (cand_idx == IdxBits'(i))) begin
        cand_onehot[i] = 1'b1;
        cand_len       = AWLEN_MS[i*LenBits +: LenBits];
      end
    end
  end

  assign aw_hs  = (state_q == WRITESTATE_IDLE)   && cand_found && AWREADY_S;
  assign w_beat = (state_q == WRITESTATE_WTRANS) && WVALID && WREADY_S;
  assign b_hs   = (state_q == WRITESTATE_BTRANS) && BVALID_S && BREADY;

  // beat_cnt still holds the index of the beat being accepted. WLAST is
  // therefore correct only when that index equals the latched AWLEN.
  assign len_mismatch = w_beat && (WLAST != (beat_cnt == len_q));

  // Next-state and grant-select decode. In idle the grant follows the live
  // candidate so that AW passes through with no added latency. The illegal
  // encoding selects nobody and falls back to idle.
  always_comb begin
    state_d    = state_q;
    sel_Master = '0;
    case (state_q)
      WRITESTATE_IDLE: begin
        sel_Master = cand_onehot;
        if (aw_hs) state_d = WRITESTATE_WTRANS;
      end
      WRITESTATE_WTRANS: begin
        sel_Master = grant_q;
        if (w_beat && WLAST) state_d = WRITESTATE_BTRANS;
      end
      WRITESTATE_BTRANS: begin
        sel_Master = grant_q;
        if (b_hs) state_d = WRITESTATE_IDLE;
      end
      default: begin
        sel_Master = '0;
        state_d    = WRITESTATE_IDLE;
      end
    endcase
  end

  // State, grant, burst length, beat counter and sticky error registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= WRITESTATE_IDLE;
      busy_q    <= 1'b0;
      grant_q   <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      wlast_err <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != WRITESTATE_IDLE);
      if (aw_hs) begin
        grant_q  <= cand_onehot;
        len_q    <= cand_len;
        beat_cnt <= '0;
      end else if (w_beat) begin
        beat_cnt <= beat_cnt + LenBits'(1);
      end
      if (len_mismatch) begin
        wlast_err <= 1'b1;
      end
    end
  end

  assign state = state_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_write_arbiter
//
// Self-checking bench for axi_write_arbiter (MasterCount=2, LenBits=4).
// Directed scenarios and a randomized run are compared against a
// transaction-level reference model kept in this file. If
// WARB_FIXED_PRIO_EN is defined, the model uses fixed priority.
// ---------------------------------------------------------------------------
module tb_axi_write_arbiter;

  localparam int N  = 2;
  localparam int LB = 4;

  logic            ACLK;
  logic            ARESETn;
  logic [N-1:0]    AWVALID_MS;
  logic [N*LB-1:0] AWLEN_MS;
  logic            AWREADY_S;
  logic            WVALID;
  logic            WREADY_S;
  logic            WLAST;
  logic            BVALID_S;
  logic            BREADY;
  logic [1:0]      state;
  logic [N-1:0]    sel_Master;
  logic            busy;
  logic [LB-1:0]   beat_cnt;
  logic            wlast_err;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 data, 2 response.
  int m_state, m_grant, m_len, m_cnt, m_rr;
  bit m_err;

  axi_write_arbiter #(.MasterCount(N), .LenBits(LB)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .AWVALID_MS(AWVALID_MS), .AWLEN_MS(AWLEN_MS),
    .AWREADY_S(AWREADY_S), .WVALID(WVALID), .WREADY_S(WREADY_S), .WLAST(WLAST),
    .BVALID_S(BVALID_S), .BREADY(BREADY), .state(state), .sel_Master(sel_Master),
    .busy(busy), .beat_cnt(beat_cnt), .wlast_err(wlast_err)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // The winner is the first requester at or after the pointer, wrapping around.
  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (AWVALID_MS[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_sel();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (m_state == 0) begin
      w = m_winner();
      if (w >= 0) r[w] = 1'b1;
    end else begin
      r[m_grant] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_grant = 0; m_len = 0; m_cnt = 0; m_rr = 0; m_err = 1'b0;
  endtask

  // Advances the model by one clock edge, using the inputs present at that edge.
  task automatic model_clock();
    int w;
    case (m_state)
      0: begin
        w = m_winner();
        if (w >= 0 && AWREADY_S) begin
          m_grant = w;
          m_len   = int'((AWLEN_MS >> (w * LB)) & ((1 << LB) - 1));
          m_cnt   = 0;
          m_state = 1;
        end
      end
      1: if (WVALID && WREADY_S) begin
        if ((WLAST == 1'b1) != (m_cnt == m_len)) m_err = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << LB);
        if (WLAST) m_state = 2;
      end
      2: if (BVALID_S && BREADY) begin
        m_state = 0;
`ifndef WARB_FIXED_PRIO_EN
        m_rr = (m_grant + 1) % N;
`endif
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge ACLK);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    AWVALID_MS = '0; AWLEN_MS = '0; AWREADY_S = 1'b0; WVALID = 1'b0;
    WREADY_S = 1'b0; WLAST = 1'b0; BVALID_S = 1'b0; BREADY = 1'b0;
  endtask

  task automatic set_len(input int m, input int len);
    AWLEN_MS[m*LB +: LB] = LB'(len);
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    model_reset();
    #3 ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESETn = 1'b0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    checks++; if (sel_Master !== '0) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 00", sel_Master); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (beat_cnt !== '0) begin errors++; $display("[TB] FAIL reset_beat: got %0d expected 0", beat_cnt); end
    checks++; if (wlast_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", wlast_err); end
    #3 ARESETn = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_order [4];
`ifdef WARB_FIXED_PRIO_EN
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    clear_inputs();
    AWVALID_MS = '1; AWREADY_S = 1'b1;
    for (int b = 0; b < 4; b++) begin
      WVALID = 1'b0; WREADY_S = 1'b0; WLAST = 1'b0; BVALID_S = 1'b0; BREADY = 1'b0;
      #1;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rr_idle_gap[%0d]: got %0d expected 0", b, state); end
      checks++; if (sel_Master !== exp_order[b]) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %b expected %b", b, sel_Master, exp_order[b]); end
      checks++; if (sel_Master !== m_sel()) begin errors++; $display("[TB] FAIL rr_model[%0d]: got %b expected %b", b, sel_Master, m_sel()); end
      tick();
      WVALID = 1'b1; WREADY_S = 1'b1; WLAST = 1'b1;
      #1;
      checks++; if (state !== 2'd1 || sel_Master !== exp_order[b]) begin errors++; $display("[TB] FAIL rr_wtrans[%0d]: got state %0d sel %b expected 1 %b", b, state, sel_Master, exp_order[b]); end
      tick();
      WVALID = 1'b0; WLAST = 1'b0; BVALID_S = 1'b1; BREADY = 1'b1;
      #1;
      checks++; if (state !== 2'd2 || wlast_err !== 1'b0) begin errors++; $display("[TB] FAIL rr_btrans[%0d]: got state %0d err %b expected 2 0", b, state, wlast_err); end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (state !== 2'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_end: got state %0d busy %b expected 0 0", state, busy); end
  endtask

  task automatic test_single_master();
    clear_inputs();
    AWVALID_MS = 2'b01; set_len(0, 3); AWREADY_S = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || sel_Master !== 2'b01) begin errors++; $display("[TB] FAIL single_idle: got state %0d sel %b expected 0 01", state, sel_Master); end
    tick();
    AWVALID_MS = '0; AWREADY_S = 1'b0;
    for (int i = 0; i < 4; i++) begin
      WVALID = 1'b1; WREADY_S = 1'b1; WLAST = (i == 3);
      #1;
      checks++; if (state !== 2'd1 || sel_Master !== 2'b01 || beat_cnt !== LB'(i)) begin
        errors++; $display("[TB] FAIL single_beat[%0d]: got state %0d sel %b cnt %0d expected 1 01 %0d", i, state, sel_Master, beat_cnt, i);
      end
      tick();
    end
    WVALID = 1'b0; WREADY_S = 1'b0; WLAST = 1'b0;
    #1;
    checks++; if (state !== 2'd2 || beat_cnt !== 4'd4 || wlast_err !== 1'b0 || sel_Master !== 2'b01) begin
      errors++; $display("[TB] FAIL single_btrans: got state %0d cnt %0d err %b sel %b expected 2 4 0 01", state, beat_cnt, wlast_err, sel_Master);
    end
    BVALID_S = 1'b1; BREADY = 1'b1;
    tick();
    BVALID_S = 1'b0; BREADY = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || sel_Master !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_done: got state %0d sel %b busy %b expected 0 00 0", state, sel_Master, busy);
    end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    AWVALID_MS = 2'b01; set_len(0, 3); AWREADY_S = 1'b1;
    #1; tick();
    AWVALID_MS = '0; AWREADY_S = 1'b0;
    WVALID = 1'b1; WREADY_S = 1'b1;
    #1; tick();
    WREADY_S = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (beat_cnt !== 4'd1 || sel_Master !== 2'b01 || state !== 2'd1) begin
        errors++; $display("[TB] FAIL bp_hold[%0d]: got cnt %0d sel %b state %0d expected 1 01 1", c, beat_cnt, sel_Master, state);
      end
      tick();
    end
    for (int i = 1; i < 4; i++) begin
      WREADY_S = 1'b1; WLAST = (i == 3);
      #1; tick();
    end
    WVALID = 1'b0; WREADY_S = 1'b0; WLAST = 1'b0;
    AWVALID_MS = 2'b10; AWREADY_S = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (state !== 2'd2 || sel_Master !== 2'b01 || beat_cnt !== 4'd4) begin
        errors++; $display("[TB] FAIL bp_btrans_hold[%0d]: got state %0d sel %b cnt %0d expected 2 01 4", c, state, sel_Master, beat_cnt);
      end
      tick();
    end
    BVALID_S = 1'b1; BREADY = 1'b1;
    #1; tick();
    BVALID_S = 1'b0; BREADY = 1'b0; AWREADY_S = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || sel_Master !== 2'b10) begin errors++; $display("[TB] FAIL bp_idle_cand: got state %0d sel %b expected 0 10", state, sel_Master); end
    AWVALID_MS = '0;
    #1;
    checks++; if (sel_Master !== 2'b00) begin errors++; $display("[TB] FAIL bp_no_req: got %b expected 00", sel_Master); end
  endtask

  task automatic test_early_wlast();
    clear_inputs();
    AWVALID_MS = 2'b10; set_len(0, 1); set_len(1, 3); AWREADY_S = 1'b1;
    #1; tick();
    AWVALID_MS = '0; AWREADY_S = 1'b0;
    WVALID = 1'b1; WREADY_S = 1'b1; WLAST = 1'b0;
    #1; tick();
    WLAST = 1'b1;
    #1;
    checks++; if (wlast_err !== 1'b0 || sel_Master !== 2'b10) begin errors++; $display("[TB] FAIL early_pre: got err %b sel %b expected 0 10", wlast_err, sel_Master); end
    tick();
    WVALID = 1'b0; WREADY_S = 1'b0; WLAST = 1'b0;
    #1;
    checks++; if (state !== 2'd2 || wlast_err !== 1'b1 || beat_cnt !== 4'd2) begin
      errors++; $display("[TB] FAIL early_flag: got state %0d err %b cnt %0d expected 2 1 2", state, wlast_err, beat_cnt);
    end
    BVALID_S = 1'b1; BREADY = 1'b1;
    tick();
    BVALID_S = 1'b0; BREADY = 1'b0;
    AWVALID_MS = 2'b10; set_len(1, 0); AWREADY_S = 1'b1;
    #1; tick();
    AWVALID_MS = '0; AWREADY_S = 1'b0;
    WVALID = 1'b1; WREADY_S = 1'b1; WLAST = 1'b1;
    #1; tick();
    WVALID = 1'b0; WREADY_S = 1'b0; WLAST = 1'b0; BVALID_S = 1'b1; BREADY = 1'b1;
    #1;
    checks++; if (state !== 2'd2 || wlast_err !== 1'b1) begin errors++; $display("[TB] FAIL early_sticky: got state %0d err %b expected 2 1", state, wlast_err); end
    tick();
    BVALID_S = 1'b0; BREADY = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || wlast_err !== 1'b1) begin errors++; $display("[TB] FAIL early_sticky_idle: got state %0d err %b expected 0 1", state, wlast_err); end
  endtask

  task automatic test_missing_wlast();
    clear_inputs();
    AWVALID_MS = 2'b01; set_len(0, 1); AWREADY_S = 1'b1;
    #1; tick();
    AWVALID_MS = '0; AWREADY_S = 1'b0;
    WVALID = 1'b1; WREADY_S = 1'b1; WLAST = 1'b0;
    #1;
    checks++; if (wlast_err !== 1'b0) begin errors++; $display("[TB] FAIL missing_clean: got err %b expected 0", wlast_err); end
    tick();
    #1; tick();
    #1;
    checks++; if (wlast_err !== 1'b1 || state !== 2'd1 || beat_cnt !== 4'd2) begin
      errors++; $display("[TB] FAIL missing_flag: got err %b state %0d cnt %0d expected 1 1 2", wlast_err, state, beat_cnt);
    end
    WLAST = 1'b1;
    tick();
    WVALID = 1'b0; WREADY_S = 1'b0; WLAST = 1'b0;
    #1;
    checks++; if (state !== 2'd2 || wlast_err !== 1'b1) begin errors++; $display("[TB] FAIL missing_btrans: got state %0d err %b expected 2 1", state, wlast_err); end
    BVALID_S = 1'b1; BREADY = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      AWVALID_MS = N'($urandom_range(0, (1 << N) - 1));
      for (int m = 0; m < N; m++) set_len(m, int'($urandom_range(0, 3)));
      AWREADY_S = ($urandom_range(0, 3) != 0);
      WVALID    = ($urandom_range(0, 3) != 0);
      WREADY_S  = ($urandom_range(0, 3) != 0);
      WLAST     = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1) : (m_cnt == m_len);
      BVALID_S  = ($urandom_range(0, 2) != 0);
      BREADY    = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (state !== 2'(m_state) || busy !== (m_state != 0) || sel_Master !== m_sel() ||
                    beat_cnt !== LB'(m_cnt) || wlast_err !== m_err) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got state %0d busy %b sel %b cnt %0d err %b expected %0d %b %b %0d %b",
                 c, state, busy, sel_Master, beat_cnt, wlast_err, m_state, (m_state != 0), m_sel(), m_cnt, m_err);
      end
      tick();
    end
  endtask

  task automatic test_midburst_reset();
    do_reset();
    AWVALID_MS = 2'b01; set_len(0, 0); AWREADY_S = 1'b1;
    #1; tick();
    AWVALID_MS = '0; AWREADY_S = 1'b0;
    WVALID = 1'b1; WREADY_S = 1'b1; WLAST = 1'b0;
    #1; tick();
    #1; tick();
    checks++; if (state !== 2'd1 || beat_cnt !== 4'd2 || wlast_err !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_pre: got state %0d cnt %0d err %b expected 1 2 1", state, beat_cnt, wlast_err);
    end
    #2 ARESETn = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || sel_Master !== 2'b00 || beat_cnt !== 4'd0 || wlast_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_async: got state %0d sel %b cnt %0d err %b busy %b expected 0 00 0 0 0",
                         state, sel_Master, beat_cnt, wlast_err, busy);
    end
    model_reset();
    clear_inputs();
    #3 ARESETn = 1'b1;
  endtask

  initial begin
    clear_inputs();
    ARESETn = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_single_master();
    test_backpressure();
    test_early_wlast();
    do_reset();
    test_missing_wlast();
    test_random();
    test_midburst_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
